// File: rtl/hdmi_timing_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hdmi_timing_driver
// Brief    : Video timing master (default 800x600@60), pixel request + aligned
//            hs/vs/de/rgb output. Optional macro HDMI_BORDER_EN adds a white
//            1-pixel border.
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_timing_driver #(
    parameter logic [10:0] H_SYNC   = 11'd128,
    parameter logic [10:0] H_BACK   = 11'd88,
    parameter logic [10:0] H_DISP   = 11'd800,
    parameter logic [10:0] H_FRONT  = 11'd40,
    parameter logic [10:0] V_SYNC   = 11'd4,
    parameter logic [10:0] V_BACK   = 11'd23,
    parameter logic [10:0] V_DISP   = 11'd600,
    parameter logic [10:0] V_FRONT  = 11'd1,
    parameter logic        SYNC_POL = 1'b1
) (
    input  logic        pixel_clk,
    input  logic        sys_rst_n,
    input  logic [23:0] pixel_data,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic        video_hs,
    output logic        video_vs,
    output logic        video_de,
    output logic [23:0] video_rgb,
    output logic        frame_start
);

    localparam logic [10:0] H_TOTAL     = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam logic [10:0] V_TOTAL     = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam logic [10:0] H_LAST      = H_TOTAL - 11'd1;
    localparam logic [10:0] V_LAST      = V_TOTAL - 11'd1;
    localparam logic [10:0] HA          = H_SYNC + H_BACK;
    localparam logic [10:0] VA          = V_SYNC + V_BACK;
    localparam logic [10:0] H_END       = HA + H_DISP;
    localparam logic [10:0] V_END       = VA + V_DISP;
    localparam logic [10:0] H_REQ_START = HA - 11'd1;
    localparam logic [10:0] H_REQ_END   = H_END - 11'd1;

    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic        h_wrap;
    logic        hs_int;
    logic        vs_int;
    logic        v_act;
    logic        act;
    logic        req;

    assign h_wrap = (h_cnt == H_LAST);
    assign hs_int = (h_cnt < H_SYNC);
    assign vs_int = (v_cnt < V_SYNC);
    assign v_act  = (v_cnt >= VA) && (v_cnt < V_END);
    assign act    = (h_cnt >= HA) && (h_cnt < H_END) && v_act;
    // Requests run one cycle ahead of act to cover the generator's register stage.
    assign req    = (h_cnt >= H_REQ_START) && (h_cnt < H_REQ_END) && v_act;

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt <= 11'd0;
            v_cnt <= 11'd0;
        end else if (h_wrap) begin
            h_cnt <= 11'd0;
            v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pixel_xpos <= 11'd0;
            pixel_ypos <= 11'd0;
        end else begin
            pixel_xpos <= req ? (h_cnt - H_REQ_START) : 11'd0;
            pixel_ypos <= req ? (v_cnt - VA) : 11'd0;
        end
    end

    // video_de doubles as the data-valid pipe: it lines up with pixel_data.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            video_hs    <= ~SYNC_POL;
            video_vs    <= ~SYNC_POL;
            video_de    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            video_hs    <= hs_int ? SYNC_POL : ~SYNC_POL;
            video_vs    <= vs_int ? SYNC_POL : ~SYNC_POL;
            video_de    <= act;
            frame_start <= (h_cnt == 11'd0) && (v_cnt == 11'd0);
        end
    end

`ifdef HDMI_BORDER_EN
    localparam logic [10:0] V_LAST_ACT = V_END - 11'd1;
    localparam logic [23:0] BORDER_RGB = 24'hFFFFFF;

    logic border_edge;
    logic border_pipe;

    assign border_edge = act && ((h_cnt == HA) || (h_cnt == H_REQ_END) ||
                                 (v_cnt == VA) || (v_cnt == V_LAST_ACT));

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            border_pipe <= 1'b0;
        end else begin
            border_pipe <= border_edge;
        end
    end

    assign video_rgb = !video_de  ? 24'h0 :
                       border_pipe ? BORDER_RGB : pixel_data;
`else
    assign video_rgb = video_de ? pixel_data : 24'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hdmi_timing_driver.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for hdmi_timing_driver on a reduced 17x10 raster (8x5 active);
// expected pixels queued by stimulus, popped by a negedge monitor.
module tb_hdmi_timing_driver;

    localparam logic POL   = 1'b1;
    localparam int   HTOT  = 17;
    localparam int   FRAME = 170;
    localparam int   HACT  = 7;
    localparam int   HSW   = 4;
    localparam int   VSW   = 34;
    localparam int   HDISP = 8;
    localparam int   VDISP = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] pixel_data = 24'h0;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic        video_hs;
    logic        video_vs;
    logic        video_de;
    logic [23:0] video_rgb;
    logic        frame_start;

    bit          white;
    bit          mon_en;
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [23:0] exp_q[$];

    hdmi_timing_driver #(
        .H_SYNC(11'd4), .H_BACK(11'd3), .H_DISP(11'd8), .H_FRONT(11'd2),
        .V_SYNC(11'd2), .V_BACK(11'd2), .V_DISP(11'd5), .V_FRONT(11'd1),
        .SYNC_POL(POL)
    ) dut (
        .pixel_clk  (clk),
        .sys_rst_n  (rst_n),
        .pixel_data (pixel_data),
        .pixel_xpos (pixel_xpos),
        .pixel_ypos (pixel_ypos),
        .video_hs   (video_hs),
        .video_vs   (video_vs),
        .video_de   (video_de),
        .video_rgb  (video_rgb),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Pattern generator model: registered, one cycle behind the request.
    always @(posedge clk) begin
        if (white)
            pixel_data <= 24'hFFFFFF;
        else
`ifdef HDMI_BORDER_EN
            pixel_data <= 24'h00FF00;
`else
            pixel_data <= {2'b00, pixel_xpos, pixel_ypos};
`endif
    end

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [23:0] exp_pix(input int x, input int y, input bit wh);
        if (wh) return 24'hFFFFFF;
`ifdef HDMI_BORDER_EN
        if (x == 0 || x == HDISP-1 || y == 0 || y == VDISP-1) return 24'hFFFFFF;
        return 24'h00FF00;
`else
        return {2'b00, 11'(x), 11'(y)};
`endif
    endfunction

    task automatic push_px(input int lines, input int tail_x, input bit wh);
        for (int y = 0; y < lines; y++)
            for (int x = 0; x < HDISP; x++) exp_q.push_back(exp_pix(x, y, wh));
        for (int x = 0; x < tail_x; x++) exp_q.push_back(exp_pix(x, lines, wh));
    endtask

    task automatic check_reset(input string tag);
        check(video_hs == ~POL,    {tag, "_hs"},   video_hs,    ~POL);
        check(video_vs == ~POL,    {tag, "_vs"},   video_vs,    ~POL);
        check(video_de == 1'b0,    {tag, "_de"},   video_de,    0);
        check(video_rgb == 24'h0,  {tag, "_rgb"},  video_rgb,   0);
        check(frame_start == 1'b0, {tag, "_fs"},   frame_start, 0);
        check(pixel_xpos == 11'd0, {tag, "_xpos"}, pixel_xpos,  0);
        check(pixel_ypos == 11'd0, {tag, "_ypos"}, pixel_ypos,  0);
    endtask

    task automatic wait_fs();
        bit got = 1'b0;
        for (int i = 0; i < 2*FRAME && !got; i++) begin
            @(negedge clk);
            if (frame_start) got = 1'b1;
        end
        check(got, "fs_timeout", got, 1);
        #1;
    endtask

    // Monitor: timing measurements and scoreboard pops on every de cycle.
    int cyc = 0, hs_run, vs_run, de_run, de_lines, hs_rise_cyc, fs_cyc;
    bit p_hs, p_vs, p_de, p_fs;
    always @(negedge clk) begin
        logic        hs_a, vs_a;
        logic [23:0] e;
        cyc++;
        hs_a = (video_hs == POL);
        vs_a = (video_vs == POL);
        if (!mon_en) begin
            hs_run = 0; vs_run = 0; de_run = 0; de_lines = 0;
            hs_rise_cyc = -1; fs_cyc = -1;
            p_hs = 0; p_vs = 0; p_de = 0; p_fs = 0;
        end else begin
            if (hs_a && !p_hs) begin
                if (hs_rise_cyc >= 0)
                    check(cyc - hs_rise_cyc == HTOT, "hs_period", cyc - hs_rise_cyc, HTOT);
                hs_rise_cyc = cyc;
            end
            if (hs_a) hs_run++;
            else if (p_hs) begin
                check(hs_run == HSW, "hs_width", hs_run, HSW);
                hs_run = 0;
            end
            if (vs_a) vs_run++;
            else if (p_vs) begin
                check(vs_run == VSW, "vs_width", vs_run, VSW);
                vs_run = 0;
            end
            if (video_de) begin
                if (!p_de)
                    check(cyc - hs_rise_cyc == HACT, "de_offset", cyc - hs_rise_cyc, HACT);
                de_run++;
                check(exp_q.size() != 0, "rgb_underflow", video_rgb, 0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check(video_rgb == e, "rgb", video_rgb, e);
                end
            end else begin
                check(video_rgb == 24'h0, "blank_rgb", video_rgb, 0);
                if (p_de) begin
                    check(de_run == HDISP, "de_width", de_run, HDISP);
                    de_run = 0;
                    de_lines++;
                end
            end
            if (frame_start) begin
                check(!p_fs, "fs_width", p_fs, 0);
                if (!p_fs) begin
                    check(hs_a && vs_a, "fs_align", {hs_a, vs_a}, 2'b11);
                    if (fs_cyc >= 0) begin
                        check(cyc - fs_cyc == FRAME, "fs_period", cyc - fs_cyc, FRAME);
                        check(de_lines == VDISP, "de_lines", de_lines, VDISP);
                    end
                    fs_cyc = cyc;
                    de_lines = 0;
                end
            end
            p_hs = hs_a; p_vs = vs_a; p_de = video_de; p_fs = frame_start;
        end
    end

    initial begin
        rst_n = 1'b0; white = 1'b0; mon_en = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset("rst");
        push_px(VDISP, 0, 1'b0);
        push_px(VDISP, 0, 1'b0);
        push_px(VDISP, 0, 1'b1);
        push_px(2, 3, 1'b0);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        wait_fs();
        wait_fs();
        wait_fs();
        white = 1'b1;
        wait_fs();
        white = 1'b0;
        // Counter reaches (h=10, v=6): active pixel x=3 of line y=2 is being requested.
        repeat (111) @(negedge clk);
        #1;
        mon_en = 1'b0;
        check(pixel_xpos == 11'd3, "pre_rst_xpos", pixel_xpos, 3);
        check(pixel_ypos == 11'd2, "pre_rst_ypos", pixel_ypos, 2);
        check(video_de == 1'b1, "pre_rst_de", video_de, 1);
        check(exp_q.size() == 0, "q_drained_1", exp_q.size(), 0);
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        repeat (3) @(negedge clk);
        #1;
        check_reset("rst_hold");
        push_px(VDISP, 0, 1'b0);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        @(negedge clk);
        #1;
        check(video_hs == POL, "hs_restart", video_hs, POL);
        check(frame_start == 1'b1, "fs_restart", frame_start, 1);
        wait_fs();
        repeat (5) @(negedge clk);
        #1;
        check(exp_q.size() == 0, "q_drained_2", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
